// File: rtl/arb_pkg.sv
// Shared types and width helpers for the stream round-robin arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int beat_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester-side and sink-side stream signals of the round-robin arbiter.
interface stream_rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req_vld;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_rdy;
    logic                     out_vld;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic [ID_W-1:0]          out_id;
    logic                     out_rdy;

    // Arbiter view: consumes requester beats, produces the merged stream.
    modport slave (
        input  req_vld, req_data, req_last, out_rdy,
        output req_rdy, out_vld, out_data, out_last, out_id
    );

    // Environment view: drives requesters and the sink ready.
    modport master (
        output req_vld, req_data, req_last, out_rdy,
        input  req_rdy, out_vld, out_data, out_last, out_id
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vld,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    pick_id,
    output logic               pick_vld
);
    localparam int SUM_W = ID_W + 1;

    logic [2*NUM_REQ-1:0] vld_dbl;
    logic [NUM_REQ-1:0]   vld_rot;
    logic [ID_W-1:0]      offset;
    logic [SUM_W-1:0]     sum;

    // Doubling the vector makes the rotation a plain part-select.
    assign vld_dbl = {req_vld, req_vld};
    assign vld_rot = vld_dbl[rr_ptr +: NUM_REQ];

    always_comb begin
        pick_vld = 1'b0;
        offset   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vld_rot[i]) begin
                pick_vld = 1'b1;
                offset   = ID_W'(i);
            end
        end
    end

    assign sum     = {1'b0, rr_ptr} + {1'b0, offset};
    assign pick_id = ID_W'((sum >= SUM_W'(NUM_REQ)) ? (sum - SUM_W'(NUM_REQ)) : sum);

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_REQ streams into one registered output.
// Optional ARB_STATS_EN adds a saturating stall_cycles counter port.
module stream_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 64,
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    stream_rr_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);
    localparam int ID_W   = id_width(NUM_REQ);
    localparam int BEAT_W = beat_width(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              out_vld_q, out_vld_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;

    logic [WIDTH-1:0]   lane_data [NUM_REQ];
    logic [NUM_REQ-1:0] rdy_vec;
    logic               can_load;
    logic               accept;
    logic               burst_done;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W-1:0]    pick_id;
    logic               pick_vld;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_vld  (bus.req_vld),
        .rr_ptr   (rr_ptr_q),
        .pick_id  (pick_id),
        .pick_vld (pick_vld)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign can_load = !out_vld_q || bus.out_rdy;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_data[gi] = bus.req_data[gi*WIDTH +: WIDTH];
            assign rdy_vec[gi]   = (state_q == ARB_LOCKED) && (grant_id_q == ID_W'(gi)) && can_load;
        end
    endgenerate

    assign bus.req_rdy = rdy_vec;
    assign accept      = (state_q == ARB_LOCKED) && bus.req_vld[grant_id_q] && can_load;
    assign burst_done  = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
    assign next_ptr    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_id_d   = out_id_q;

        if (out_vld_q && bus.out_rdy) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_id_d = pick_id;
                    state_d    = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (accept) begin
                    out_vld_d  = 1'b1;
                    out_data_d = lane_data[grant_id_q];
                    out_id_d   = grant_id_q;
                    // A forced release is flagged downstream as end-of-packet too.
                    if (bus.req_last[grant_id_q] || burst_done) begin
                        out_last_d = 1'b1;
                        beat_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                        state_d    = ARB_IDLE;
                    end else begin
                        out_last_d = 1'b0;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_id_q   <= out_id_d;
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign bus.out_last = out_last_q;
    assign bus.out_id   = out_id_q;

`ifdef ARB_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_vld_q && !bus.out_rdy && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized scoreboard bench for stream_rr_arbiter with directed scenarios
// (latency, rotation, burst cap, back-pressure, reset) and a random soak.
module tb_stream_rr_arbiter;
    import arb_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 64;
    localparam int MAX_BURST = 8;
    localparam int ID_W      = id_width(NUM_REQ);
    localparam int MAXB      = 512;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

`ifdef ARB_STATS_EN
    logic [31:0] stall_cycles;
`endif

    stream_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef ARB_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Per-requester beat tables (stimulus) and the reference model state
    logic [WIDTH-1:0] lane_data [NUM_REQ][MAXB];
    logic             lane_last [NUM_REQ][MAXB];
    int               lane_len [NUM_REQ];
    int               lane_pos [NUM_REQ];
    int               lane_first_cyc [NUM_REQ];
    int               start_pct = 100;
    int               rdy_pct   = 100;
    logic [NUM_REQ-1:0] acc_flag = '0;

    exp_t sb[$];
    int   log_id[$];
    int   log_cyc[$];
    bit   m_idle  = 1'b1;
    int   m_ptr   = 0;
    int   m_grant = 0;
    int   m_beats = 0;
    int   stall_m = 0;

    bit               hold_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [ID_W-1:0]  prev_id;
    logic             prev_last;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_choice(input logic [NUM_REQ-1:0] v, input int ptr);
        int j;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (ptr + k) % NUM_REQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic add_packet(input int lane, input int nbeats, input bit with_last);
        for (int b = 0; b < nbeats; b++) begin
            lane_data[lane][lane_len[lane]] = {$urandom, $urandom};
            lane_last[lane][lane_len[lane]] = with_last && (b == nbeats - 1);
            lane_len[lane]++;
        end
    endtask

    // Driver: owns every DUT input; updates shortly after each rising edge.
    initial begin
        bus.req_vld  = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.out_rdy  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_rdy = ($urandom_range(99) < rdy_pct);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rst) begin
                    bus.req_vld[i] = 1'b0;
                end else begin
                    if (acc_flag[i]) begin
                        lane_pos[i]++;
                        bus.req_vld[i] = 1'b0;
                    end
                    if (!bus.req_vld[i] && (lane_pos[i] < lane_len[i]) &&
                        ($urandom_range(99) < start_pct)) begin
                        bus.req_vld[i]                  = 1'b1;
                        bus.req_data[i*WIDTH +: WIDTH]  = lane_data[i][lane_pos[i]];
                        bus.req_last[i]                 = lane_last[i][lane_pos[i]];
                        if (lane_pos[i] == 0) lane_first_cyc[i] = cyc;
                    end
                end
            end
        end
    end

    // Monitor: sampled on the falling edge; pops the scoreboard on output beats,
    // pushes expectations on accepted input beats.
    initial begin
        exp_t               e;
        logic [NUM_REQ-1:0] exp_rdy;
        logic               exp_last;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_flag  = '0;
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_vld",  bus.out_vld,  1);
                    check("hold_data", bus.out_data, prev_data);
                    check("hold_id",   bus.out_id,   prev_id);
                    check("hold_last", bus.out_last, prev_last);
                end
                if (bus.out_vld && !bus.out_rdy) stall_m++;
                if (bus.out_vld && bus.out_rdy) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", bus.out_vld, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_id",   bus.out_id,   e.id);
                        check("out_data", bus.out_data, e.data);
                        check("out_last", bus.out_last, e.last);
                        log_id.push_back(int'(bus.out_id));
                        log_cyc.push_back(cyc);
                        $display("beat cyc=%0d id=%0d data=%h last=%0b", cyc, bus.out_id,
                                 bus.out_data, bus.out_last);
                    end
                end
                hold_prev = bus.out_vld && !bus.out_rdy;
                prev_data = bus.out_data;
                prev_id   = bus.out_id;
                prev_last = bus.out_last;

                exp_rdy = '0;
                if (!m_idle) exp_rdy[m_grant] = !bus.out_vld || bus.out_rdy;
                check("req_rdy", bus.req_rdy, exp_rdy);

                acc_flag = bus.req_vld & bus.req_rdy;
                if (m_idle) begin
                    if (|bus.req_vld) begin
                        m_grant = rr_choice(bus.req_vld, m_ptr);
                        m_idle  = 1'b0;
                    end
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (acc_flag[i]) begin
                            exp_last = lane_last[i][lane_pos[i]] || (m_beats == MAX_BURST - 1);
                            sb.push_back('{id: i, data: lane_data[i][lane_pos[i]], last: exp_last});
                            if (exp_last) begin
                                m_idle  = 1'b1;
                                m_ptr   = (i + 1) % NUM_REQ;
                                m_beats = 0;
                            end else begin
                                m_beats++;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_len[i] = 0;
            lane_pos[i] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("rst_out_vld",  bus.out_vld,  0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_id",   bus.out_id,   0);
        check("rst_req_rdy",  bus.req_rdy,  0);
        @(posedge clk);
        #2;
        sb.delete();
        log_id.delete();
        log_cyc.delete();
        m_idle  = 1'b1;
        m_ptr   = 0;
        m_beats = 0;
        stall_m = 0;
        rst     = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
            done = (sb.size() == 0) && !bus.out_vld && (bus.req_vld == '0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lane_pos[i] != lane_len[i]) done = 1'b0;
            end
        end
        check("drain_done", done, 1);
    endtask

    initial begin
        int exp_ids[$];
        int n;
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_len[i] = 0;
            lane_pos[i] = 0;
            lane_first_cyc[i] = 0;
        end

        // Single 3-beat packet: two-cycle latency, one beat per cycle
        do_reset();
        add_packet(0, 3, 1'b1);
        wait_drain(100);
        check("s1_beats", log_cyc.size(), 3);
        for (int k = 0; k < log_cyc.size() && k < 3; k++) begin
            check("s1_beat_cycle", log_cyc[k], lane_first_cyc[0] + 2 + k);
        end

        // All requesters busy with 1-beat packets: strict rotation
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int p = 0; p < 6; p++) add_packet(i, 1, 1'b1);
        end
        wait_drain(400);
        check("s2_beats", log_id.size(), 6 * NUM_REQ);
        for (int k = 0; k < log_id.size(); k++) check("s2_rotation", log_id[k], k % NUM_REQ);

        // Long packet on req2 is cut at MAX_BURST so waiting req1 gets a turn
        do_reset();
        add_packet(2, 20, 1'b1);
        repeat (3) @(negedge clk);
        add_packet(1, 3, 1'b1);
        wait_drain(400);
        exp_ids.delete();
        for (int k = 0; k < 8; k++) exp_ids.push_back(2);
        for (int k = 0; k < 3; k++) exp_ids.push_back(1);
        for (int k = 0; k < 12; k++) exp_ids.push_back(2);
        check("s3_beats", log_id.size(), exp_ids.size());
        for (int k = 0; k < log_id.size() && k < exp_ids.size(); k++) begin
            check("s3_order", log_id[k], exp_ids[k]);
        end

        // Sink back-pressure for exactly five cycles in mid-burst
        do_reset();
        add_packet(0, 20, 1'b1);
        n = 0;
        while (!bus.out_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s4_first_out", bus.out_vld, 1);
        rdy_pct = 0;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rdy_pct = 100;
        wait_drain(200);
        check("s4_beats", log_id.size(), 20);
        check("s4_stall_model", stall_m, 5);
`ifdef ARB_STATS_EN
        check("s6_stall_cycles", stall_cycles, 5);
`endif

        // Reset in mid-burst, then a fresh request from req3
        do_reset();
        add_packet(0, 16, 1'b1);
        repeat (6) @(negedge clk);
        do_reset();
        add_packet(3, 2, 1'b1);
        wait_drain(100);
        check("s5_beats", log_id.size(), 2);
        if (log_id.size() > 0) check("s5_first_id", log_id[0], 3);

        // Random soak: mixed lengths, occasional unterminated packets, random sink ready
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int p = 0; p < 8; p++) begin
                    add_packet(i, $urandom_range(12, 1), $urandom_range(99) >= 20);
                end
            end
            start_pct = $urandom_range(90, 30);
            rdy_pct   = $urandom_range(90, 40);
            wait_drain(5000);
        end
        start_pct = 100;
        rdy_pct   = 100;
        repeat (3) @(negedge clk);
        check("soak_sb_empty", sb.size(), 0);
`ifdef ARB_STATS_EN
        check("soak_stall_cycles", stall_cycles, stall_m);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

endmodule
